// File: rtl/usb_reg_bus_master.sv
// Initiator for the 8-bit ChipWhisperer USB register bus: converts (addr, dir, len) commands plus a
// byte stream into registered ALEn/CEn/RDn/WRn cycles. Write bytes are pulled only when a strobe can start.
module usb_reg_bus_master #(
    parameter int pLEN_WIDTH     = 8,
    parameter int pALE_CYCLES    = 3,
    parameter int pSTROBE_CYCLES = 4,
    parameter int pGAP_CYCLES    = 4
) (
    input  logic                  cwusb_clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [7:0]            cmd_addr,
    input  logic [pLEN_WIDTH-1:0] cmd_len,
    input  logic [7:0]            wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            bus_addr,
    output logic [7:0]            bus_dout,
    input  logic [7:0]            bus_din,
    input  logic                  bus_isout,
    output logic                  bus_alen,
    output logic                  bus_cen,
    output logic                  bus_rdn,
    output logic                  bus_wrn
);

    localparam int MAX_AS = (pALE_CYCLES > pSTROBE_CYCLES) ? pALE_CYCLES : pSTROBE_CYCLES;
    localparam int MAXC   = (MAX_AS > pGAP_CYCLES) ? MAX_AS : pGAP_CYCLES;
    localparam int CW     = $clog2(MAXC);
    localparam logic [CW-1:0] ALE_LAST = CW'(pALE_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(pSTROBE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(pGAP_CYCLES - 1);

    if (pALE_CYCLES < 3 || pSTROBE_CYCLES < 3 || pGAP_CYCLES < 3 || pLEN_WIDTH < 1) begin : g_param_check
        $error("usb_reg_bus_master: pALE/pSTROBE/pGAP_CYCLES must be >= 3 and pLEN_WIDTH >= 1");
    end

    typedef enum logic [2:0] {S_IDLE, S_ALE, S_ALE_HOLD, S_STROBE, S_GAP, S_DONE} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [pLEN_WIDTH-1:0] r_len;
    logic [pLEN_WIDTH-1:0] r_bytes;
    logic                  r_write;

    logic [CW-1:0] w_last;
    logic          w_can_strobe;

    // ALE_HOLD and GAP share the "wait, then DONE or next strobe" exit logic
    assign w_last       = (r_state == S_GAP) ? GAP_LAST : ALE_LAST;
    assign w_can_strobe = !r_write || wr_valid;

    always_ff @(posedge cwusb_clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_bytes   <= '0;
            r_write   <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
            wr_ready  <= 1'b0;
            rd_data   <= 8'h00;
            bus_addr  <= 8'h00;
            bus_dout  <= 8'h00;
            bus_alen  <= 1'b1;
            bus_cen   <= 1'b1;
            bus_rdn   <= 1'b1;
            bus_wrn   <= 1'b1;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            wr_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_write   <= cmd_write;
                        r_len     <= cmd_len;
                        r_bytes   <= '0;
                        bus_addr  <= cmd_addr;
                        bus_alen  <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_ALE;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_ALE: begin
                    if (r_cnt == ALE_LAST) begin
                        bus_alen <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_ALE_HOLD;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_ALE_HOLD, S_GAP: begin
                    if (r_cnt != w_last) begin
                        r_cnt <= r_cnt + CW'(1);
                    end else if (r_bytes == r_len) begin
                        bus_cen <= 1'b1;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_can_strobe) begin
                        bus_cen <= 1'b0;
                        if (r_write) begin
                            bus_wrn  <= 1'b0;
                            bus_dout <= wr_data;
                            wr_ready <= 1'b1;
                        end else begin
                            bus_rdn <= 1'b0;
                        end
                        r_cnt   <= '0;
                        r_state <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    if (r_cnt == STB_LAST) begin
                        bus_rdn <= 1'b1;
                        bus_wrn <= 1'b1;
                        r_bytes <= r_bytes + pLEN_WIDTH'(1);
                        if (!r_write) begin
                            rd_data  <= bus_din;
                            rd_valid <= 1'b1;
                        end
                        r_cnt   <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    a_strobe_excl: assert property (@(posedge cwusb_clk) disable iff (reset) !(!bus_rdn && !bus_wrn));
    a_ale_cen:     assert property (@(posedge cwusb_clk) disable iff (reset) !(!bus_alen && !bus_cen));
    // slave must not drive its DOUT while we drive a write strobe
    a_no_contend:  assert property (@(posedge cwusb_clk) disable iff (reset) !(!bus_wrn && bus_isout));

endmodule
